nn_inst_fetch: RTL and testbench

//  Instruction-fetch initiator for Block_Memory's instruction port. Drives the 16-bit

---
 rtl/nn_inst_fetch.sv | 198 +++++++++++++++++++
 tb/tb_nn_inst_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inst_fetch.sv
// ---------------------------------------------------------------------------
// nn_inst_fetch
//   Instruction-fetch initiator for the Block_Memory instruction port.
//   Issues instruction addresses, captures the returned word one cycle later,
//   buffers up to two words and hands them to the NN decoder over valid/ready.
//   A redirect reloads the PC and flushes queued and in-flight fetches.
//
//   Build option:
//     FETCH_HALT_DETECT_EN - when defined, a word whose top nibble is 4'hF acts
//       as a halt: fetching stops once it is enqueued, and the unit enters HALT
//       when the decoder takes it. istart resumes at the following address.
//       When undefined, 4'hF is an ordinary opcode and ohalted is tied low.
//
//   Ports:
//     iclk, irst_n       clock, asynchronous active-low reset
//     istart             pulse: begin/resume fetching (IDLE/HALT -> RUN)
//     iredirect          pulse: load PC from iredirect_addr, flush queue
//     iredirect_addr     new PC on redirect
//     oInstAddr          instruction address to Block_Memory
//     iInstr             instruction word from Block_Memory
//     oinstr, oinstr_pc  head-of-queue word and its address
//     oinstr_valid       head valid
//     iinstr_ready       decoder accepts head when valid & ready
//     obusy              unit is in RUN
//     ohalted            unit is in HALT
// ---------------------------------------------------------------------------
module nn_inst_fetch #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         INSTR_W  = 24,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               istart,
    input  logic               iredirect,
    input  logic [ADDR_W-1:0]  iredirect_addr,
    output logic [ADDR_W-1:0]  oInstAddr,
    input  logic [INSTR_W-1:0] iInstr,
    output logic [INSTR_W-1:0] oinstr,
    output logic [ADDR_W-1:0]  oinstr_pc,
    output logic               oinstr_valid,
    input  logic               iinstr_ready,
    output logic               obusy,
    output logic               ohalted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [ADDR_W-1:0]  pc, pcNext;
    logic [ADDR_W-1:0]  addrQ, addrNext;
    logic [ADDR_W-1:0]  issueAddr;
    logic               inFlight, inFlightNext;
    logic [ADDR_W-1:0]  flightPc, flightPcNext;
    logic               haltPending, haltPendingNext;

    // Two-entry queue; entry 0 is always the head.
    logic [INSTR_W-1:0] qData0, qData1, qData0Next, qData1Next;
    logic [ADDR_W-1:0]  qPc0, qPc1, qPc0Next, qPc1Next;
    logic [1:0]         count, countNext;

    logic               pop;
    logic               push;
    logic               pushHalt;
    logic               popHalt;
    logic [1:0]         base;
    logic [1:0]         occ;
    logic               issue;

    assign oInstAddr    = addrQ;
    assign oinstr       = qData0;
    assign oinstr_pc    = qPc0;
    assign oinstr_valid = (count != 2'd0);
    assign obusy        = (state == RUN);

    assign pop  = (count != 2'd0) && iinstr_ready;
    // A redirect discards the word returning this cycle.
    assign push = inFlight && !iredirect;

`ifdef FETCH_HALT_DETECT_EN
    // Issuing stops once a halt word is enqueued, so any 4'hF word in the
    // queue is necessarily the last one and its transfer ends the run.
    assign pushHalt = push && (iInstr[INSTR_W-1 -: 4] == 4'hF);
    assign popHalt  = pop  && (qData0[INSTR_W-1 -: 4] == 4'hF);
    assign ohalted  = (state == HALT);
`else
    assign pushHalt = 1'b0;
    assign popHalt  = 1'b0;
    assign ohalted  = 1'b0;
`endif

    // Occupancy after this edge: queue plus the word being captured, less the
    // word leaving. Issuing against it lets a transfer free a slot the same
    // cycle, which is what sustains one word per cycle.
    assign base = count - {1'b0, pop};
    assign occ  = iredirect ? 2'd0 : (base + {1'b0, push});

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (istart)  stateNext = RUN;
            RUN:     if (popHalt) stateNext = HALT;
            HALT:    if (istart)  stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        issueAddr = iredirect ? iredirect_addr : pc;
        issue     = (stateNext == RUN) && (occ < 2'd2) &&
                    (iredirect || !(haltPending || pushHalt));

        pcNext       = pc;
        addrNext     = addrQ;
        inFlightNext = issue;
        flightPcNext = flightPc;

        if (iredirect) begin
            pcNext = iredirect_addr;
        end
        if (issue) begin
            pcNext       = issueAddr + ADDR_W'(1);
            addrNext     = issueAddr;
            flightPcNext = issueAddr;
        end
    end

    always_comb begin
        qData0Next = qData0;
        qData1Next = qData1;
        qPc0Next   = qPc0;
        qPc1Next   = qPc1;
        countNext  = count;

        if (pop) begin
            qData0Next = qData1;
            qPc0Next   = qPc1;
        end

        if (iredirect) begin
            countNext = 2'd0;
        end else begin
            if (push) begin
                if (base == 2'd0) begin
                    qData0Next = iInstr;
                    qPc0Next   = flightPc;
                end else begin
                    qData1Next = iInstr;
                    qPc1Next   = flightPc;
                end
            end
            countNext = occ;
        end
    end

    always_comb begin
        haltPendingNext = haltPending;
        if (iredirect || popHalt) begin
            haltPendingNext = 1'b0;
        end else if (pushHalt) begin
            haltPendingNext = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            addrQ       <= RESET_PC;
            inFlight    <= 1'b0;
            flightPc    <= '0;
            haltPending <= 1'b0;
            qData0      <= '0;
            qData1      <= '0;
            qPc0        <= '0;
            qPc1        <= '0;
            count       <= 2'd0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            addrQ       <= addrNext;
            inFlight    <= inFlightNext;
            flightPc    <= flightPcNext;
            haltPending <= haltPendingNext;
            qData0      <= qData0Next;
            qData1      <= qData1Next;
            qPc0        <= qPc0Next;
            qPc1        <= qPc1Next;
            count       <= countNext;
        end
    end

endmodule

// File: tb/tb_nn_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_nn_inst_fetch
//   Directed bench for nn_inst_fetch. The instruction memory is modelled as
//   returning word(addr) for the address currently on oInstAddr; word(addr) is
//   {8'hA5, addr}, except that address 5 holds 24'hF00000 when haltWordEn is set.
// ---------------------------------------------------------------------------
module tb_nn_inst_fetch;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        istart;
    logic        iredirect;
    logic [15:0] iredirect_addr;
    logic [15:0] oInstAddr;
    logic [23:0] iInstr;
    logic [23:0] oinstr;
    logic [15:0] oinstr_pc;
    logic        oinstr_valid;
    logic        iinstr_ready;
    logic        obusy;
    logic        ohalted;

    logic        haltWordEn = 1'b0;
    logic [15:0] got[$];

    int checks   = 0;
    int failures = 0;

    nn_inst_fetch #(
        .ADDR_W  (16),
        .INSTR_W (24),
        .RESET_PC(16'h0000)
    ) dut (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .istart        (istart),
        .iredirect     (iredirect),
        .iredirect_addr(iredirect_addr),
        .oInstAddr     (oInstAddr),
        .iInstr        (iInstr),
        .oinstr        (oinstr),
        .oinstr_pc     (oinstr_pc),
        .oinstr_valid  (oinstr_valid),
        .iinstr_ready  (iinstr_ready),
        .obusy         (obusy),
        .ohalted       (ohalted)
    );

    always #5 iclk = ~iclk;

    function automatic logic [23:0] memWord(input logic [15:0] a, input logic hw);
        if (hw && (a == 16'h0005)) return 24'hF00000;
        return {8'hA5, a};
    endfunction

    assign iInstr = memWord(oInstAddr, haltWordEn);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transfer monitor: records each accepted pc and checks its word.
    always begin
        @(negedge iclk);
        #2;
        if (irst_n && oinstr_valid && iinstr_ready) begin
            got.push_back(oinstr_pc);
            check("xfer_data", 32'(oinstr), 32'(memWord(oinstr_pc, haltWordEn)));
        end
    end

    task automatic waitGot(input string name, input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge iclk);
            #3;
            k++;
        end
        check(name, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic checkGot(input string name, input int unsigned idx, input logic [15:0] exp);
        check(name, (got.size() > idx) ? 32'(got[idx]) : 32'hDEAD_BEEF, 32'(exp));
    endtask

    task automatic checkResetOutputs(input string p);
        check({p, "_addr"},   32'(oInstAddr),    32'h0);
        check({p, "_valid"},  32'(oinstr_valid), 32'h0);
        check({p, "_pc"},     32'(oinstr_pc),    32'h0);
        check({p, "_instr"},  32'(oinstr),       32'h0);
        check({p, "_busy"},   32'(obusy),        32'h0);
        check({p, "_halted"}, 32'(ohalted),      32'h0);
    endtask

    task automatic doReset();
        irst_n         = 1'b0;
        istart         = 1'b0;
        iredirect      = 1'b0;
        iredirect_addr = 16'h0;
        iinstr_ready   = 1'b0;
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
    endtask

    task automatic startFetch(input logic ready);
        iinstr_ready = ready;
        istart       = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
    endtask

    typedef struct packed {
        logic        start;
        logic        ready;
        logic [15:0] expAddr;
        logic        expValid;
        logic [15:0] expPc;
        logic        expBusy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        irst_n         = 1'b0;
        istart         = 1'b0;
        iredirect      = 1'b0;
        iredirect_addr = 16'h0;
        iinstr_ready   = 1'b0;

        @(negedge iclk);
        checkResetOutputs("rst");
        irst_n = 1'b1;
        @(negedge iclk);

        // Start with ready high, stall two cycles, resume.
        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0001, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h0002, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'h0003, 1'b1, 16'h0002, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h0003, 1'b1, 16'h0002, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0003, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 16'h0005, 1'b1, 16'h0004, 1'b1};

        for (int i = 0; i < 8; i++) begin
            istart       = vecs[i].start;
            iinstr_ready = vecs[i].ready;
            @(posedge iclk);
            @(negedge iclk);
            check($sformatf("vec%0d_addr", i),  32'(oInstAddr),    32'(vecs[i].expAddr));
            check($sformatf("vec%0d_valid", i), 32'(oinstr_valid), 32'(vecs[i].expValid));
            check($sformatf("vec%0d_busy", i),  32'(obusy),        32'(vecs[i].expBusy));
            if (vecs[i].expValid) begin
                check($sformatf("vec%0d_pc", i), 32'(oinstr_pc), 32'(vecs[i].expPc));
            end
        end
        istart = 1'b0;

        // Decoder stalled after start: two words held, address frozen.
        doReset();
        got.delete();
        startFetch(1'b0);
        repeat (10) @(negedge iclk);
        check("stall_valid", 32'(oinstr_valid), 32'd1);
        check("stall_pc",    32'(oinstr_pc),    32'h0);
        check("stall_addr",  32'(oInstAddr),    32'h1);
        check("stall_none",  32'(got.size()),   32'd0);
        iinstr_ready = 1'b1;
        waitGot("stall_wait", 4, 20);
        for (int i = 0; i < 4; i++) checkGot($sformatf("stall_order%0d", i), i, 16'(i));

        // Redirect with a full queue.
        doReset();
        startFetch(1'b0);
        repeat (4) @(negedge iclk);
        got.delete();
        iredirect      = 1'b1;
        iredirect_addr = 16'h0040;
        @(negedge iclk);
        iredirect = 1'b0;
        check("redir_valid", 32'(oinstr_valid), 32'd0);
        check("redir_addr",  32'(oInstAddr),    32'h40);
        iinstr_ready = 1'b1;
        waitGot("redir_wait", 3, 20);
        for (int i = 0; i < 3; i++) checkGot($sformatf("redir_pc%0d", i), i, 16'h0040 + 16'(i));

        // Redirect near the top of the address space: PC wraps.
        iinstr_ready = 1'b0;
        @(negedge iclk);
        @(negedge iclk);
        got.delete();
        iredirect      = 1'b1;
        iredirect_addr = 16'hFFFE;
        @(negedge iclk);
        iredirect    = 1'b0;
        iinstr_ready = 1'b1;
        waitGot("wrap_wait", 4, 20);
        checkGot("wrap_pc0", 0, 16'hFFFE);
        checkGot("wrap_pc1", 1, 16'hFFFF);
        checkGot("wrap_pc2", 2, 16'h0000);
        checkGot("wrap_pc3", 3, 16'h0001);

        // Word 24'hF00000 at address 5.
        doReset();
        haltWordEn = 1'b1;
        got.delete();
        startFetch(1'b1);
`ifdef FETCH_HALT_DETECT_EN
        waitGot("halt_wait", 6, 30);
        for (int i = 0; i < 6; i++) checkGot($sformatf("halt_pc%0d", i), i, 16'(i));
        repeat (6) @(negedge iclk);
        check("halt_flag",  32'(ohalted),      32'd1);
        check("halt_busy",  32'(obusy),        32'd0);
        check("halt_valid", 32'(oinstr_valid), 32'd0);
        check("halt_count", 32'(got.size()),   32'd6);
        startFetch(1'b1);
        waitGot("resume_wait", 7, 20);
        checkGot("resume_pc", 6, 16'h0006);
        check("resume_flag", 32'(ohalted), 32'd0);
`else
        waitGot("ophF_wait", 8, 30);
        for (int i = 0; i < 8; i++) checkGot($sformatf("ophF_pc%0d", i), i, 16'(i));
        check("ophF_halted", 32'(ohalted), 32'd0);
        check("ophF_busy",   32'(obusy),   32'd1);
`endif
        haltWordEn = 1'b0;

        // Asynchronous reset with two words queued.
        doReset();
        startFetch(1'b0);
        repeat (4) @(negedge iclk);
        check("arst_pre_valid", 32'(oinstr_valid), 32'd1);
        check("arst_pre_addr",  32'(oInstAddr),    32'h1);
        #1;
        irst_n = 1'b0;
        #1;
        checkResetOutputs("arst");
        @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        check("arst_idle_busy", 32'(obusy), 32'd0);
        got.delete();
        startFetch(1'b1);
        waitGot("arst_wait", 2, 20);
        checkGot("arst_pc0", 0, 16'h0000);
        checkGot("arst_pc1", 1, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
